// File: rtl/transposer_pkg.sv
// Shared parameters and state encoding for the transposer scratch buffer.
package transposer_pkg;

    localparam int AW_DEF    = 16;  // word address width
    localparam int BUFFD_DEF = 64;  // bytes per word
    localparam int DW_DEF    = 10;  // depth exponent

    // Zero-fill sweep controller states
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sbuf_state_e;

endpackage

// File: rtl/transposer_sbuf_mem.sv
// 1R1W word array with byte-strobe writes and a registered, write-first read.
// Contents are never reset; a hard macro can replace this module.
module transposer_sbuf_mem #(
    parameter int BUFFD = 64,
    parameter int DW    = 10
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [DW-1:0]      waddr_i,
    input  logic [BUFFD*8-1:0] wdata_i,
    input  logic [BUFFD-1:0]   wstrb_i,
    input  logic               re_i,
    input  logic [DW-1:0]      raddr_i,
    output logic [BUFFD*8-1:0] rdata_o
);
    localparam int DEPTH = 1 << DW;

    logic [BUFFD*8-1:0] mem_q [DEPTH];
    logic [BUFFD*8-1:0] rd_d;
    logic [BUFFD*8-1:0] rdata_q;

    // Byte-masked write into the array
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BUFFD; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Read word with same-cycle write bytes merged in (write-first)
    always_comb begin
        rd_d = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            for (int b = 0; b < BUFFD; b++) begin
                if (wstrb_i[b]) rd_d[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    // Capture read at issue so a later write cannot disturb it
    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= rd_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/transposer_sbuf.sv
// Transposer scratch buffer: 2-cycle pipelined reads, byte-strobe writes,
// out-of-range detection with sticky err, and a zero-fill sweep on init_pulse.
module transposer_sbuf
    import transposer_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int BUFFD = BUFFD_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               init_pulse,
    output logic               busy,
    input  logic [AW-1:0]      raddr,
    input  logic               raddr_vld,
    output logic [BUFFD*8-1:0] rdata,
    output logic               rdata_vld,
    input  logic [AW-1:0]      waddr,
    input  logic [BUFFD*8-1:0] wdata,
    input  logic [BUFFD-1:0]   wstrb,
    input  logic               wdata_vld,
    output logic               err
);
    localparam int          DEPTH    = 1 << DW;
    localparam logic [DW:0] CNT_LAST = (DW+1)'(DEPTH - 1);

    sbuf_state_e        state_q, state_d;
    logic [DW:0]        cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [1:0]         vld_pipe_q;   // [0] array read captured, [1] rdata valid
    logic               zero_q;       // stage-1 read must return zero
    logic [BUFFD*8-1:0] rdata_q;

    logic               clearing, r_oor, w_oor, user_we;
    logic               mem_we;
    logic [DW-1:0]      mem_waddr;
    logic [BUFFD*8-1:0] mem_wdata, mem_rdata;
    logic [BUFFD-1:0]   mem_wstrb;

    assign clearing = (state_q == CLEAR);
    assign r_oor    = |raddr[AW-1:DW];
    assign w_oor    = |waddr[AW-1:DW];
    assign user_we  = wdata_vld && !w_oor && !clearing;

    // The sweep owns the write port while clearing; user writes are dropped then
    assign mem_we    = clearing || user_we;
    assign mem_waddr = clearing ? cnt_q[DW-1:0] : waddr[DW-1:0];
    assign mem_wdata = clearing ? '0 : wdata;
    assign mem_wstrb = clearing ? '1 : wstrb;

    transposer_sbuf_mem #(
        .BUFFD (BUFFD),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .wstrb_i (mem_wstrb),
        .re_i    (raddr_vld),
        .raddr_i (raddr[DW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Sweep FSM next state: init restarts from 0, last word returns to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (init_pulse) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (init_pulse) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Sticky error: init clears it, but an error event in the same cycle wins
    always_comb begin
        err_d = init_pulse ? 1'b0 : err_q;
        if ((raddr_vld && r_oor) || (wdata_vld && (w_oor || clearing))) err_d = 1'b1;
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Read pipeline: valid shift, zero-return flag, output data register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            zero_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], raddr_vld};
            if (raddr_vld)     zero_q  <= r_oor || clearing;
            if (vld_pipe_q[0]) rdata_q <= zero_q ? '0 : mem_rdata;
        end
    end

    assign busy      = clearing;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign rdata_vld = vld_pipe_q[1];

endmodule

// File: tb/tb_transposer_sbuf.sv
// Scoreboard bench for transposer_sbuf: driver updates a plain array model and
// queues expected read data; a negedge monitor pops and compares each rdata_vld.
module tb_transposer_sbuf;
    localparam int AW    = 16;
    localparam int BUFFD = 64;
    localparam int DW    = 10;
    localparam int DEPTH = 1024;
    localparam int DWB   = BUFFD * 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             init_pulse = 1'b0;
    logic             busy;
    logic [AW-1:0]    raddr = '0;
    logic             raddr_vld = 1'b0;
    logic [DWB-1:0]   rdata;
    logic             rdata_vld;
    logic [AW-1:0]    waddr = '0;
    logic [DWB-1:0]   wdata = '0;
    logic [BUFFD-1:0] wstrb = '0;
    logic             wdata_vld = 1'b0;
    logic             err;

    transposer_sbuf #(.AW(AW), .BUFFD(BUFFD), .DW(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .init_pulse (init_pulse),
        .busy       (busy),
        .raddr      (raddr),
        .raddr_vld  (raddr_vld),
        .rdata      (rdata),
        .rdata_vld  (rdata_vld),
        .waddr      (waddr),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wdata_vld  (wdata_vld),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DWB-1:0] data;
        int             exp_cyc;
    } exp_t;

    exp_t           sb[$];
    logic [DWB-1:0] model [DEPTH];
    int             busy_rem = 0;
    bit             model_err = 0;
    int             n_tests = 0;
    int             n_fail = 0;

    task automatic chk(input string name, input logic [DWB-1:0] act, input logic [DWB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DWB-1:0] merge(input logic [DWB-1:0] old, input logic [DWB-1:0] nw,
                                             input logic [BUFFD-1:0] strb);
        logic [DWB-1:0] r;
        r = old;
        for (int b = 0; b < BUFFD; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DWB-1:0] rnd_word();
        logic [DWB-1:0] w;
        for (int i = 0; i < DWB/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock of stimulus; the model is updated from the behavioural rules
    task automatic op(input bit rd, input logic [AW-1:0] ra, input bit wr, input logic [AW-1:0] wa,
                      input logic [DWB-1:0] wd, input logic [BUFFD-1:0] ws, input bit ini);
        bit   in_clear, roor, woor;
        exp_t e;
        in_clear = (busy_rem > 0);
        roor = (ra >= DEPTH);
        woor = (wa >= DEPTH);
        raddr_vld = rd; raddr = ra;
        wdata_vld = wr; waddr = wa; wdata = wd; wstrb = ws;
        init_pulse = ini;
        if (rd) begin
            e.exp_cyc = cyc + 2;
            if (in_clear || roor) e.data = '0;
            else if (wr && !woor && wa == ra) e.data = merge(model[ra[DW-1:0]], wd, ws);
            else e.data = model[ra[DW-1:0]];
            sb.push_back(e);
        end
        if (wr && !in_clear && !woor) model[wa[DW-1:0]] = merge(model[wa[DW-1:0]], wd, ws);
        if (ini) model_err = 0;
        if ((rd && roor) || (wr && (woor || in_clear))) model_err = 1;
        if (ini) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            busy_rem = DEPTH;
        end else if (busy_rem > 0) begin
            busy_rem--;
        end
        @(posedge clk); #1;
        raddr_vld = 0; wdata_vld = 0; init_pulse = 0;
        chk("busy", DWB'(busy), DWB'(busy_rem > 0));
        chk("err", DWB'(err), DWB'(model_err));
    endtask

    task automatic idle();
        op(0, '0, 0, '0, '0, '0, 0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        op(1, a, 0, '0, '0, '0, 0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DWB-1:0] d, input logic [BUFFD-1:0] s);
        op(0, '0, 1, a, d, s, 0);
    endtask

    task automatic init_and_wait();
        op(0, '0, 0, '0, '0, '0, 1);
        while (busy_rem > 0) idle();
    endtask

    task automatic rand_op();
        logic [AW-1:0] ra, wa;
        ra = AW'($urandom_range(0, 15));
        wa = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) ra = AW'(16'h0400 | $urandom_range(0, 16'hFBFF));
        if ($urandom_range(0, 15) == 0) wa = AW'(16'h0400 | $urandom_range(0, 16'hFBFF));
        op($urandom_range(0, 1) == 1, ra, $urandom_range(0, 1) == 1, wa, rnd_word(),
           {$urandom, $urandom}, 0);
    endtask

    // One-cycle reset: in-flight reads are discarded, outputs forced to zero
    task automatic pulse_reset();
        reset_n = 0;
        @(posedge clk); #1;
        sb.delete();
        busy_rem = 0;
        model_err = 0;
        chk("rst_rdata_vld", DWB'(rdata_vld), '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_busy", DWB'(busy), '0);
        chk("rst_err", DWB'(err), '0);
        reset_n = 1;
    endtask

    // Monitor: every rdata_vld must match the oldest queued expectation on time
    always @(negedge clk) begin
        exp_t e;
        if (rdata_vld) begin
            if (sb.size() == 0) begin
                chk("unexpected_rdata_vld", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.data);
                chk("rd_latency", DWB'(cyc), DWB'(e.exp_cyc));
            end
        end else if (sb.size() > 0 && sb[0].exp_cyc < cyc) begin
            e = sb.pop_front();
            chk("missing_rdata_vld", DWB'(cyc), DWB'(e.exp_cyc));
        end
    end

    initial begin
        logic [DWB-1:0] x, old9, a5, ff0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata_vld0", DWB'(rdata_vld), '0);
        chk("rst_busy0", DWB'(busy), '0);
        chk("rst_err0", DWB'(err), '0);
        chk("rst_rdata0", rdata, '0);
        reset_n = 1;
        idle();

        // Full sweep then read every word back as zero
        init_and_wait();
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));
        repeat (3) idle();

        // Byte-strobe merge on address 5
        for (int b = 0; b < BUFFD; b++) a5[b*8 +: 8] = 8'hA5;
        ff0 = '0; ff0[7:0] = 8'hFF;
        wr(16'd5, a5, '1);
        wr(16'd5, ff0, 64'h1);
        wr(16'd5, rnd_word(), '0);
        rd(16'd5);
        repeat (3) idle();
        chk("byte_merge", model[5], {a5[DWB-1:8], 8'hFF});

        // Write-first on same cycle; in-flight read keeps old data
        x = rnd_word();
        op(1, 16'd7, 1, 16'd7, x, '1, 0);
        old9 = rnd_word();
        wr(16'd9, old9, '1);
        rd(16'd9);
        wr(16'd9, rnd_word(), '1);
        rd(16'd9);
        repeat (3) idle();

        // Out-of-range read and write, err stays set until init
        op(1, 16'h0400, 1, 16'hFFFF, rnd_word(), '1, 0);
        rd(16'h03FF);
        repeat (5) idle();

        // Randomised traffic around a few hot addresses
        for (int i = 0; i < 400; i++) rand_op();
        repeat (3) idle();

        // Init with a same-cycle error, traffic during the sweep, restart mid-sweep
        op(1, 16'h0800, 0, '0, '0, '0, 1);
        for (int i = 0; i < 60; i++) rand_op();
        for (int i = 0; i < 200; i++) idle();
        op(0, '0, 0, '0, '0, '0, 1);
        while (busy_rem > 0) idle();
        for (int i = 0; i < 300; i++) rand_op();

        // Back-to-back reads, reset mid-stream, then keep reading
        for (int i = 0; i < 64; i++) rd(AW'($urandom_range(0, 15)));
        pulse_reset();
        for (int i = 0; i < 16; i++) rd(AW'($urandom_range(0, 15)));
        repeat (3) idle();

        // Reset in the middle of a sweep aborts it; re-init before use
        op(0, '0, 0, '0, '0, '0, 1);
        for (int i = 0; i < 100; i++) idle();
        pulse_reset();
        repeat (3) idle();
        init_and_wait();
        for (int i = 0; i < 32; i++) rd(AW'($urandom_range(0, DEPTH - 1)));
        repeat (4) idle();

        chk("sb_drained", DWB'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/transposer_sbuf.md
TRANSPOSER_SBUF -- requirements
Module: transposer_sbuf

Interface
REQ-001 Parameters: AW=16, address width; BUFFD=64, word bytes (data width BUFFD*8); DW=10, depth exponent, DEPTH=2**DW words.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 init_pulse  input  1  one-cycle request to start zero-fill sweep.
REQ-005 busy  output  1  high while the zero-fill sweep runs.
REQ-006 raddr  input  AW  read word address from transposer.
REQ-007 raddr_vld  input  1  read request strobe.
REQ-008 rdata  output  BUFFD*8  read data.
REQ-009 rdata_vld  output  1  read data valid, one pulse per accepted read.
REQ-010 waddr  input  AW  write word address from transposer.
REQ-011 wdata  input  BUFFD*8  write data.
REQ-012 wstrb  input  BUFFD  per-byte write enable (bit i gates wdata[8i+7:8i]).
REQ-013 wdata_vld  input  1  write strobe.
REQ-014 err  output  1  sticky error flag.

Function
- Read path
  - REQ-015 Every cycle with raddr_vld=1 SHALL produce exactly one rdata_vld pulse 2 cycles later, fully pipelined (1 read/cycle, no backpressure).
  - REQ-016 Read ordering SHALL be preserved.
- Write path
  - REQ-017 A write with wdata_vld=1 SHALL update the addressed bytes selected by wstrb in that same cycle; wstrb=0 writes nothing.
- Hazards and address range
  - REQ-018 Same-cycle read and write to one address SHALL be write-first: rdata reflects the merged new bytes.
  - REQ-019 A write arriving while a read of the same address is in flight (cycle +1) SHALL NOT alter that read's returned data (read samples the array at issue).
  - REQ-020 Address >= DEPTH (any of bits AW-1..DW set): the write SHALL be dropped; the read SHALL return all-zero data with rdata_vld still pulsed; both SHALL set err.
- Zero-fill state machine (IDLE, CLEAR)
  - REQ-021 IDLE->CLEAR on init_pulse; a counter SHALL write zero to address 0..DEPTH-1, one word per cycle.
  - REQ-022 CLEAR->IDLE after address DEPTH-1 is written; busy high for exactly DEPTH cycles, starting the cycle after init_pulse.
  - REQ-023 init_pulse during CLEAR SHALL restart the counter at 0.
  - REQ-024 During CLEAR, writes SHALL be dropped and set err; reads SHALL return zero with normal 2-cycle rdata_vld.
  - REQ-025 init_pulse SHALL clear err in the same edge it is sampled; error events in that same cycle SHALL win (err=1).
- Widths
  - REQ-026 Array index = address[DW-1:0]; sweep counter DW+1 bits, no wrap.

Reset
REQ-027 reset_n=0 SHALL force state IDLE, counter 0, busy=0, rdata=0, rdata_vld=0, err=0, and discard in-flight reads (no rdata_vld after reset).
REQ-028 Array contents SHALL NOT be reset; software SHALL issue init_pulse before first use.
REQ-029 Reset mid-CLEAR SHALL abort the sweep; a partially cleared array is permitted.

Structure
REQ-030 AW, BUFFD, DW defaults and the state enum (IDLE, CLEAR) SHALL live in the shared transposer_pkg.
REQ-031 The storage array with byte-strobe write SHALL be sub-module transposer_sbuf_mem (1R1W, registered read), replaceable by a macro.

Verification
REQ-032 init_pulse, wait for busy=0, then read addr 0..1023 -> busy high exactly 1024 cycles; all rdata=0, 1024 rdata_vld pulses.
REQ-033 Write addr 5 data 0xA5 pattern wstrb all-ones, then wstrb=0x1 with 0xFF byte0, then read 5 -> byte0=0xFF, others 0xA5; rdata_vld 2 cycles after raddr_vld.
REQ-034 Same cycle: write addr 7 = X and read addr 7 -> returns X; read addr 9 then write addr 9 next cycle -> returns old value.
REQ-035 Read addr 0x0400 and write addr 0xFFFF -> read returns 0 with rdata_vld, array unchanged, err=1 until next init_pulse.
REQ-036 Back-to-back reads every cycle for 64 cycles, then reset_n=0 for one cycle mid-stream -> no rdata_vld after reset, all outputs 0.
